e_muldiv_unit: RTL and testbench

- Multi-cycle multiply/divide unit in the E stage of the five-stage MIPS pipeline.
- Consumes the operands and decoded operation held in the E pipeline register.
- Owns the HI/LO architectural registers.
- Drives a busy/stall indication back toward the D stage so the hazard unit can freeze D and bubble E while an operation is in flight.

---
 rtl/e_muldiv_pkg.sv | 57 +++++
 rtl/e_muldiv_unit.sv | 127 ++++++++++++
 tb/tb_e_muldiv_unit.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/e_muldiv_pkg.sv
// Shared op-codes, default latencies and arithmetic helpers for the E-stage
// multiply/divide unit.
package e_muldiv_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MTHI  = 4'd5;
    localparam logic [3:0] MD_MTLO  = 4'd6;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } md_result_t;

    function automatic logic md_is_issue_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    function automatic md_result_t md_mul_s(input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{a[31]}}, a};
        eb = {{32{b[31]}}, b};
        return ea * eb;
    endfunction

    function automatic md_result_t md_mul_u(input logic [31:0] a, input logic [31:0] b);
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Magnitude divide then re-sign: quotient truncates toward zero and the
    // remainder follows the dividend; 0x80000000 / -1 falls out as 0x80000000 r 0.
    function automatic md_result_t md_div_s(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        ma = a[31] ? (32'd0 - a) : a;
        mb = b[31] ? (32'd0 - b) : b;
        q  = ma / mb;
        r  = ma % mb;
        q  = (a[31] ^ b[31]) ? (32'd0 - q) : q;
        r  = a[31] ? (32'd0 - r) : r;
        return {r, q};
    endfunction

    function automatic md_result_t md_div_u(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

endpackage

// File: rtl/e_muldiv_unit.sv
// Multi-cycle multiply/divide unit of the E stage: owns HI/LO, holds busy for a
// fixed per-op latency and commits the result on the final busy edge.
module e_muldiv_unit
    import e_muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  E_md_op,
    input  logic        E_md_start,
    input  logic [31:0] E_V1,
    input  logic [31:0] E_V2,
    output logic        md_busy,
    output logic        md_stall,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] L_MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] L_DIV_N  = 4'(DIV_CYCLES);

    logic        r_busy;
    logic [3:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_busy;
    logic [3:0]  w_cnt;
    logic [3:0]  w_op;
    logic [31:0] w_a;
    logic [31:0] w_b;
    logic [31:0] w_hi;
    logic [31:0] w_lo;
    md_result_t  w_res;

    assign w_accept = !r_busy && E_md_start && md_is_issue_op(E_md_op);

    // Result of the in-flight op, from latched operands only; divide-by-zero keeps HI/LO.
    always_comb begin
        w_res = {r_hi, r_lo};
        case (r_op)
            MD_MULT:  w_res = md_mul_s(r_a, r_b);
            MD_MULTU: w_res = md_mul_u(r_a, r_b);
            MD_DIV: begin
                if (r_b != 32'd0) begin
                    w_res = md_div_s(r_a, r_b);
                end else begin
                    w_res = {r_hi, r_lo};
                end
            end
            MD_DIVU: begin
                if (r_b != 32'd0) begin
                    w_res = md_div_u(r_a, r_b);
                end else begin
                    w_res = {r_hi, r_lo};
                end
            end
            default:  w_res = {r_hi, r_lo};
        endcase
    end

    // Next-state: issue, countdown/commit, or idle mthi/mtlo writes.
    always_comb begin
        w_busy = r_busy;
        w_cnt  = r_cnt;
        w_op   = r_op;
        w_a    = r_a;
        w_b    = r_b;
        w_hi   = r_hi;
        w_lo   = r_lo;
        if (w_accept) begin
            w_busy = 1'b1;
            w_cnt  = ((E_md_op == MD_MULT) || (E_md_op == MD_MULTU)) ? L_MULT_N : L_DIV_N;
            w_op   = E_md_op;
            w_a    = E_V1;
            w_b    = E_V2;
        end else if (r_busy) begin
            if (r_cnt <= 4'd1) begin
                w_busy = 1'b0;
                w_cnt  = 4'd0;
                w_hi   = w_res.hi;
                w_lo   = w_res.lo;
            end else begin
                w_cnt  = r_cnt - 4'd1;
            end
        end else if (E_md_op == MD_MTHI) begin
            w_hi = E_V1;
        end else if (E_md_op == MD_MTLO) begin
            w_lo = E_V1;
        end else begin
            w_hi = r_hi;
        end
    end

    // State registers; reset aborts any in-flight op.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_cnt  <= 4'd0;
            r_op   <= MD_NONE;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else begin
            r_busy <= w_busy;
            r_cnt  <= w_cnt;
            r_op   <= w_op;
            r_a    <= w_a;
            r_b    <= w_b;
            r_hi   <= w_hi;
            r_lo   <= w_lo;
        end
    end

    assign md_busy  = r_busy;
    assign md_stall = r_busy | E_md_start;
    assign HI       = r_hi;
    assign LO       = r_lo;

endmodule

// File: tb/tb_e_muldiv_unit.sv
// Scoreboard bench for e_muldiv_unit: a reference model predicts HI/LO and busy
// length per op; a negedge monitor checks them when busy falls.
module tb_e_muldiv_unit;

    localparam logic [3:0] OP_NONE  = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam int N_MULT = 5;
    localparam int N_DIV  = 10;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic        clk;
    logic        reset;
    logic [3:0]  E_md_op;
    logic        E_md_start;
    logic [31:0] E_V1;
    logic [31:0] E_V2;
    logic        md_busy;
    logic        md_stall;
    logic [31:0] HI;
    logic [31:0] LO;

    int   checks;
    int   errors;
    exp_t sb_q[$];
    logic [31:0] ref_hi;
    logic [31:0] ref_lo;

    e_muldiv_unit dut (
        .clk       (clk),
        .reset     (reset),
        .E_md_op   (E_md_op),
        .E_md_start(E_md_start),
        .E_V1      (E_V1),
        .E_V2      (E_V2),
        .md_busy   (md_busy),
        .md_stall  (md_stall),
        .HI        (HI),
        .LO        (LO)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Reference model straight from the architectural definitions.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output exp_t e);
        longint          sp;
        longint unsigned up;
        int              sa;
        int              sb;
        e.hi = ref_hi;
        e.lo = ref_lo;
        e.cycles = (op == OP_MULT || op == OP_MULTU) ? N_MULT : N_DIV;
        sa = a;
        sb = b;
        case (op)
            OP_MULT: begin
                sp = longint'(sa) * longint'(sb);
                e.hi = sp[63:32];
                e.lo = sp[31:0];
            end
            OP_MULTU: begin
                up = 64'(a) * 64'(b);
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    e.hi = ref_hi;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'd0;
                end else begin
                    e.lo = sa / sb;
                    e.hi = sa % sb;
                end
            end
            default: begin
                if (b != 32'd0) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
    endtask

    // Issue one mult/div; optionally disturb operands, try mtlo and a restart while busy.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input bit disturb);
        exp_t e;
        int   n;
        model(op, a, b, e);
        ref_hi = e.hi;
        ref_lo = e.lo;
        sb_q.push_back(e);
        @(posedge clk); #1;
        E_md_op = op; E_md_start = 1'b1; E_V1 = a; E_V2 = b;
        @(posedge clk); #1;
        E_md_op = OP_NONE; E_md_start = 1'b0;
        n = 0;
        while (md_busy && n < 40) begin
            n++;
            if (disturb) begin
                E_V1 = $urandom; E_V2 = $urandom;
                E_md_op = OP_NONE; E_md_start = 1'b0;
                if (n == 2) E_md_op = OP_MTLO;
                if (n == 3) begin
                    E_md_op = OP_DIV; E_md_start = 1'b1;
                end
            end
            @(posedge clk); #1;
        end
        E_md_op = OP_NONE; E_md_start = 1'b0;
        if (n >= 40) begin
            errors++;
            $display("FAIL busy_timeout actual=%0d expected=%0d", n, e.cycles);
        end
        @(negedge clk);
    endtask

    // mthi/mtlo while idle: old value visible in the same cycle, new value after the edge.
    task automatic run_mt(input logic [3:0] op, input logic [31:0] v);
        @(posedge clk); #1;
        E_md_op = op; E_V1 = v; E_md_start = 1'b0;
        @(negedge clk);
        if (op == OP_MTHI) check32("mthi_same_cycle_old", HI, ref_hi);
        else               check32("mtlo_same_cycle_old", LO, ref_lo);
        @(posedge clk); #1;
        E_md_op = OP_NONE;
        if (op == OP_MTHI) ref_hi = v;
        else               ref_lo = v;
        check32("mt_hi", HI, ref_hi);
        check32("mt_lo", LO, ref_lo);
    endtask

    // Monitor: stall relation every cycle; on busy falling, compare against the scoreboard.
    initial begin
        exp_t e;
        logic prev_busy;
        int   busy_run;
        prev_busy = 1'b0;
        busy_run  = 0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_busy = 1'b0;
                busy_run  = 0;
            end else begin
                check32("md_stall", {31'd0, md_stall}, {31'd0, E_md_start | md_busy});
                if (md_busy) begin
                    busy_run++;
                end else if (prev_busy) begin
                    if (sb_q.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_commit actual=%h_%h expected=none", HI, LO);
                    end else begin
                        e = sb_q.pop_front();
                        check32("commit_hi", HI, e.hi);
                        check32("commit_lo", LO, e.lo);
                        check32("busy_cycles", busy_run, e.cycles);
                    end
                    busy_run = 0;
                end
                prev_busy = md_busy;
            end
        end
    end

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        checks = 0;
        errors = 0;
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        reset = 1'b0;
        E_md_op = OP_NONE; E_md_start = 1'b0; E_V1 = 32'd0; E_V2 = 32'd0;
        #23;
        check32("rst_busy", {31'd0, md_busy}, 32'd0);
        check32("rst_stall", {31'd0, md_stall}, 32'd0);
        check32("rst_hi", HI, 32'd0);
        check32("rst_lo", LO, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        run_md(OP_MULT,  32'hFFFF_FFFE, 32'd3, 1'b0);
        check32("mult_hi_const", HI, 32'hFFFF_FFFF);
        check32("mult_lo_const", LO, 32'hFFFF_FFFA);
        run_md(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        check32("multu_hi_const", HI, 32'hFFFF_FFFE);
        check32("multu_lo_const", LO, 32'h0000_0001);
        run_md(OP_DIV,   32'hFFFF_FFF9, 32'd2, 1'b1);
        check32("div_lo_const", LO, 32'hFFFF_FFFD);
        check32("div_hi_const", HI, 32'hFFFF_FFFF);
        run_md(OP_DIVU,  32'd7, 32'd0, 1'b0);
        run_md(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_mt(OP_MTHI, 32'h0000_1234);
        run_mt(OP_MTLO, 32'hCAFE_F00D);
        run_md(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b1);

        // Start with a non-issue op code is ignored.
        @(posedge clk); #1;
        E_md_op = 4'd9; E_md_start = 1'b1; E_V1 = 32'h5555_AAAA;
        @(posedge clk); #1;
        E_md_op = OP_NONE; E_md_start = 1'b0;
        check32("bad_op_busy", {31'd0, md_busy}, 32'd0);
        check32("bad_op_hi", HI, ref_hi);
        check32("bad_op_lo", LO, ref_lo);

        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom_range(1, 6));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if (rop == OP_MTHI || rop == OP_MTLO) run_mt(rop, ra);
            else run_md(rop, ra, rb, $urandom_range(0, 1) == 1);
        end

        // Reset during busy cycle 3 of a divide aborts it without a clock edge.
        @(posedge clk); #1;
        E_md_op = OP_DIV; E_md_start = 1'b1; E_V1 = 32'd100; E_V2 = 32'd7;
        @(posedge clk); #1;
        E_md_op = OP_NONE; E_md_start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check32("pre_abort_busy", {31'd0, md_busy}, 32'd1);
        reset = 1'b0;
        #1;
        check32("abort_busy", {31'd0, md_busy}, 32'd0);
        check32("abort_hi", HI, 32'd0);
        check32("abort_lo", LO, 32'd0);
        ref_hi = 32'd0;
        ref_lo = 32'd0;
        @(posedge clk); #1;
        reset = 1'b1;
        run_md(OP_DIVU, 32'd100, 32'd7, 1'b0);
        run_md(OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0);

        repeat (3) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
